wb_burst_mem_slave: RTL

- Synthesizable Wishbone B3 slave memory; sits directly downstream of the Wishbone master BFM and is the standard target for its classic, constant and incrementing burst traffic.
- Supports registered-feedback bursts (CTI/BTE), byte selects and a configurable number of wait states.
- Terminates out-of-range accesses with an error instead of an ack.

---
 rtl/wb_burst_mem_slave.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/wb_burst_mem_slave.sv
// Wishbone B3 burst-capable memory slave with byte selects, configurable
// first-beat wait states and error termination of out-of-range accesses.

module wb_burst_mem_lane (
  input  logic       sel_i,
  input  logic [7:0] wdat_i,
  input  logic [7:0] rdat_i,
  output logic [7:0] mdat_o
);
  assign mdat_o = sel_i ? wdat_i : rdat_i;
endmodule

module wb_burst_mem_slave #(
  parameter int aw          = 32,
  parameter int dw          = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [aw-1:0]   wb_adr_i,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic [dw/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [dw-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int NSEL    = dw / 8;
  localparam int ADR_LSB = $clog2(NSEL);
  localparam int IW      = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BURST} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            oor_q, oor_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [dw-1:0]   dat_q, dat_d;

  logic [dw-1:0]   mem [MEM_DEPTH];

  logic [IW-1:0]   adr_idx, next_idx, wrap_m, rd_idx;
  logic            adr_oor, req, hs, wr_en, burst_cont;
  logic [dw-1:0]   wr_merged, rd_data;

  assign adr_idx    = wb_adr_i[ADR_LSB +: IW];
  assign adr_oor    = |(wb_adr_i >> (ADR_LSB + IW));
  assign req        = wb_cyc_i & wb_stb_i;
  assign hs         = req & (ack_q | err_q);
  assign wr_en      = hs & wb_we_i & ~oor_q;
  assign burst_cont = (wb_cti_i == 3'b001) || (wb_cti_i == 3'b010);

  // Wrapped bursts advance only the low index bits; the block base is held.
  always_comb begin
    wrap_m = '1;
    case (wb_bte_i)
      2'b01:   wrap_m = IW'(3);
      2'b10:   wrap_m = IW'(7);
      2'b11:   wrap_m = IW'(15);
      default: wrap_m = '1;
    endcase
  end

  assign next_idx = (wb_cti_i == 3'b010) ?
                    ((idx_q & ~wrap_m) | ((idx_q + IW'(1)) & wrap_m)) : idx_q;

  genvar k;
  generate
    for (k = 0; k < NSEL; k++) begin : g_lane
      wb_burst_mem_lane u_lane (
        .sel_i  (wb_sel_i[k]),
        .wdat_i (wb_dat_i[8*k +: 8]),
        .rdat_i (mem[idx_q][8*k +: 8]),
        .mdat_o (wr_merged[8*k +: 8])
      );
    end
  endgenerate

  // Read port address depends on where the data load happens; a word written
  // on this very edge is forwarded so constant bursts see fresh data.
  always_comb begin
    rd_idx = next_idx;
    if (state_q == S_IDLE)      rd_idx = adr_idx;
    else if (state_q == S_WAIT) rd_idx = idx_q;
  end

  assign rd_data = (wr_en && (rd_idx == idx_q)) ? wr_merged : mem[rd_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    oor_d   = oor_q;
    ack_d   = ack_q;
    err_d   = err_q;
    dat_d   = dat_q;
    case (state_q)
      S_IDLE: begin
        ack_d = 1'b0;
        err_d = 1'b0;
        if (req) begin
          idx_d = adr_idx;
          oor_d = adr_oor;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            state_d = S_ACK;
            ack_d   = ~adr_oor;
            err_d   = adr_oor;
            dat_d   = rd_data;
          end
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = S_ACK;
            ack_d   = ~oor_q;
            err_d   = oor_q;
            dat_d   = rd_data;
          end
        end
      end
      S_ACK, S_BURST: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
          ack_d   = 1'b0;
          err_d   = 1'b0;
        end else if (hs) begin
          if (err_q || !burst_cont) begin
            state_d = S_IDLE;
            ack_d   = 1'b0;
            err_d   = 1'b0;
          end else begin
            state_d = S_BURST;
            idx_d   = next_idx;
            dat_d   = rd_data;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge wb_clk_i) begin
    if (wr_en) mem[idx_q] <= wr_merged;
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q & wb_cyc_i & wb_stb_i;
  assign wb_err_o = err_q & wb_cyc_i & wb_stb_i;
  assign wb_rty_o = 1'b0;

endmodule
